// File: rtl/note_scheduler_if.sv
// Key/enable inputs and tone/status outputs of the shared tone generator.
// There is no ready: note_valid qualifies note_idx on every cycle it is high, and the consumer cannot stall it.
interface note_scheduler_if #(
  parameter int NUM_KEYS = 8
);
  logic [NUM_KEYS-1:0] keys;
  logic                enable;
  logic                tone;
  logic                note_valid;
  logic [2:0]          note_idx;

  modport master (output keys, enable, input tone, note_valid, note_idx);
  modport slave  (input keys, enable, output tone, note_valid, note_idx);
endinterface

// File: rtl/note_scheduler.sv
// One square-wave tone generator shared by up to 8 keys; the highest pressed key wins.
// A silent gap is inserted on every change of the sounding note.
module note_scheduler #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int NUM_KEYS   = 8,
  parameter int GAP_CYCLES = 50_000
) (
  input  logic              clk,
  input  logic              reset,
  note_scheduler_if.slave   bus,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, GAP = 2'd2} state_t;

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = (GAP_CYCLES == 0) ? '0 : GW'(GAP_CYCLES - 1);

  // Half-period in clk cycles for C4..C5, folded to constants at elaboration.
  function automatic logic [23:0] half_of(input int i);
    int f;
    case (i)
      0: f = 262;
      1: f = 294;
      2: f = 330;
      3: f = 349;
      4: f = 392;
      5: f = 440;
      6: f = 494;
      default: f = 523;
    endcase
    return 24'((CLK_HZ / 2) / f);
  endfunction

  localparam logic [23:0] HALF [8] = '{half_of(0), half_of(1), half_of(2), half_of(3),
                                       half_of(4), half_of(5), half_of(6), half_of(7)};

  state_t              state, state_d;
  logic [NUM_KEYS-1:0] ks_meta, ks;
  logic [2:0]          cur, cur_d, sel;
  logic [23:0]         div_cnt, div_d, half_cur;
  logic [GW-1:0]       gap_cnt, gap_d;
  logic                tone_q, tone_d, any;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ks_meta <= '0;
      ks      <= '0;
    end else begin
      ks_meta <= bus.keys;
      ks      <= ks_meta;
    end
  end

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_KEYS; i++)
      if (ks[i]) sel = 3'(i);
  end

  assign any      = |ks;
  assign half_cur = HALF[cur];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cur     <= '0;
      div_cnt <= '0;
      gap_cnt <= '0;
      tone_q  <= 1'b0;
    end else begin
      state   <= state_d;
      cur     <= cur_d;
      div_cnt <= div_d;
      gap_cnt <= gap_d;
      tone_q  <= tone_d;
    end
  end

  always_comb begin
    state_d = state;
    cur_d   = cur;
    div_d   = div_cnt;
    gap_d   = gap_cnt;
    tone_d  = tone_q;
    case (state)
      IDLE: begin
        tone_d = 1'b0;
        if (bus.enable && any) begin
          state_d = PLAY;
          cur_d   = sel;
          div_d   = '0;
        end
      end
      PLAY: begin
        if (!bus.enable || !any) begin
          state_d = IDLE;
          tone_d  = 1'b0;
          div_d   = '0;
        end else if (sel != cur) begin
          tone_d = 1'b0;
          if (GAP_CYCLES == 0) begin
            cur_d = sel;
            div_d = '0;
          end else begin
            state_d = GAP;
            gap_d   = '0;
          end
        end else if (div_cnt == half_cur - 24'd1) begin
          tone_d = ~tone_q;
          div_d  = '0;
        end else begin
          div_d = div_cnt + 24'd1;
        end
      end
      GAP: begin
        tone_d = 1'b0;
        if (!bus.enable || !any) begin
          state_d = IDLE;
        end else if (gap_cnt == GAP_LAST) begin
          // The note chosen is whatever is highest at the end of the gap.
          state_d = PLAY;
          cur_d   = sel;
          div_d   = '0;
        end else begin
          gap_d = gap_cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.tone       = tone_q;
  assign bus.note_valid = (state == PLAY);
  assign bus.note_idx   = cur;
  assign dbg_state      = state;

endmodule

// File: tb/tb_note_scheduler.sv
// Directed bench for note_scheduler, scaled to CLK_HZ=20000 and GAP_CYCLES=10.
// Half-periods at 20 kHz: key3 = 10000/349 = 28, key5 = 10000/440 = 22, key7 = 10000/523 = 19.
module tb_note_scheduler;

  localparam int HALF3 = 28;
  localparam int HALF5 = 22;
  localparam int HALF7 = 19;
  localparam int GAPC  = 10;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] dbg_state;
  int         passed = 0;
  int         total  = 0;

  note_scheduler_if #(.NUM_KEYS(8)) bus ();

  note_scheduler #(.CLK_HZ(20000), .NUM_KEYS(8), .GAP_CYCLES(GAPC)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic check_out(input string tag, input logic t, input logic v, input logic [2:0] idx,
                           input logic [1:0] st);
    check({tag, ".tone"},       32'(bus.tone),       32'(t));
    check({tag, ".note_valid"}, 32'(bus.note_valid), 32'(v));
    check({tag, ".note_idx"},   32'(bus.note_idx),   32'(idx));
    check({tag, ".state"},      32'(dbg_state),      32'(st));
  endtask

  initial begin
    // T1: reset held with all keys pressed
    rst_n      = 1'b0;
    bus.keys   = 8'hFF;
    bus.enable = 1'b1;
    #1;
    check_out("t1_reset_async", 1'b0, 1'b0, 3'd0, S_IDLE);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check_out("t1_reset_held", 1'b0, 1'b0, 3'd0, S_IDLE);
    end
    bus.keys = 8'h00;
    rst_n    = 1'b1;
    tick(3);
    check_out("t1_after_release", 1'b0, 1'b0, 3'd0, S_IDLE);

    // T2: key 3 alone, 3-edge latency then half-period 28
    bus.keys = 8'h08;
    tick(2);
    check("t2_edge2_valid", 32'(bus.note_valid), 32'd0);
    tick(1);
    check_out("t2_edge3_play", 1'b0, 1'b1, 3'd3, S_PLAY);
    tick(HALF3 - 1);
    check("t2_before_rise", 32'(bus.tone), 32'd0);
    tick(1);
    check("t2_rise", 32'(bus.tone), 32'd1);
    tick(HALF3 - 1);
    check("t2_before_fall", 32'(bus.tone), 32'd1);
    tick(1);
    check("t2_fall", 32'(bus.tone), 32'd0);

    // T3: add key 5 -> gap of GAPC cycles, then key 5 at half-period 22
    bus.keys = 8'h28;
    tick(2);
    check("t3_still_play", 32'(bus.note_valid), 32'd1);
    tick(1);
    check_out("t3_gap_entry", 1'b0, 1'b0, 3'd3, S_GAP);
    tick(GAPC - 1);
    check_out("t3_gap_last", 1'b0, 1'b0, 3'd3, S_GAP);
    tick(1);
    check_out("t3_play5", 1'b0, 1'b1, 3'd5, S_PLAY);
    tick(HALF5 - 1);
    check("t3_before_rise", 32'(bus.tone), 32'd0);
    tick(1);
    check("t3_rise", 32'(bus.tone), 32'd1);

    // T4: lower key added under key 5 -> no gap, phase preserved
    bus.keys = 8'h21;
    tick(HALF5 - 1);
    check_out("t4_hold", 1'b1, 1'b1, 3'd5, S_PLAY);
    tick(1);
    check_out("t4_fall", 1'b0, 1'b1, 3'd5, S_PLAY);

    // T5: switch to key 3 (gap), then release everything mid-gap
    bus.keys = 8'h08;
    tick(3);
    check_out("t5_gap_entry", 1'b0, 1'b0, 3'd5, S_GAP);
    tick(3);
    bus.keys = 8'h00;
    tick(2);
    check("t5_gap_until_sync", 32'(dbg_state), 32'(S_GAP));
    tick(1);
    check_out("t5_idle", 1'b0, 1'b0, 3'd5, S_IDLE);
    tick(15);
    check_out("t5_stays_idle", 1'b0, 1'b0, 3'd5, S_IDLE);

    // T6: mute in PLAY, unmute, then async reset pulse mid-cycle
    bus.keys = 8'h80;
    tick(3);
    check_out("t6_play7", 1'b0, 1'b1, 3'd7, S_PLAY);
    bus.enable = 1'b0;
    tick(1);
    check_out("t6_muted", 1'b0, 1'b0, 3'd7, S_IDLE);
    bus.enable = 1'b1;
    tick(1);
    check_out("t6_unmuted", 1'b0, 1'b1, 3'd7, S_PLAY);
    tick(HALF7);
    check("t6_rise", 32'(bus.tone), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("t6_async_clear", 1'b0, 1'b0, 3'd0, S_IDLE);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    check_out("t6_restart_idle", 1'b0, 1'b0, 3'd0, S_IDLE);
    tick(2);
    check_out("t6_restart_play", 1'b0, 1'b1, 3'd7, S_PLAY);

    // final report
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
